// File: rtl/fetch_icache_refill.sv
// fetch_icache_refill: line refill engine for the fetch I-cache (128 lines x 64 B, 36-bit entries).
// Optional instruction predecode bits are enabled by defining FETCH_ICACHE_REFILL_PREDECODE_EN.
module fetch_icache_refill #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        miss_valid,
  input  logic [31:0] miss_addr,
  output logic        miss_ready,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        snoop_hit,
  input  logic [31:0] snoop_addr,
  output logic        update_data_wea,
  output logic [31:0] update_data_addr,
  output logic [35:0] update_data,
  output logic        update_tag_wea,
  output logic [32:0] update_tag,
  output logic        refill_busy,
  output logic        refill_done,
  output logic        refill_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    TAG  = 2'd3
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

`ifdef FETCH_ICACHE_REFILL_PREDECODE_EN
  // MIPS-style decode: bit0 = control transfer, bit1 = writes the link register.
  function automatic logic [3:0] predecode(input logic [31:0] word);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic       ct;
    logic       lk;
    op = word[31:26];
    fn = word[5:0];
    rt = word[20:16];
    ct = ((op >= 6'd1) && (op <= 6'd7)) ||
         ((op == 6'd0) && ((fn == 6'd8) || (fn == 6'd9)));
    lk = (op == 6'd3) ||
         ((op == 6'd0) && (fn == 6'd9)) ||
         ((op == 6'd1) && ((rt == 5'd16) || (rt == 5'd17)));
    return {2'b00, lk, ct};
  endfunction
`endif

  state_t      state_r;
  state_t      state_nx;
  logic [25:0] line_r;
  logic        poison_r;
  logic [4:0]  cnt_r;
  logic        beat_valid_r;
  logic [3:0]  beat_idx_r;
  logic [31:0] beat_data_r;
  logic [31:0] timer_r;
  logic [31:0] timer_nx;
  logic        timeout_s;
  logic        beat_take_s;
  logic        snoop_match_s;
  logic [3:0]  pd_s;
  logic        unused_s;

  assign unused_s = ^{miss_addr[5:0], snoop_addr[5:0]};

  // Beats are only taken in FILL and only until all 16 have arrived; anything else is dropped.
  assign beat_take_s   = (state_r == FILL) && mem_resp_valid && !cnt_r[4];
  assign snoop_match_s = snoop_hit && (state_r != IDLE) && (snoop_addr[31:6] == line_r);

`ifdef FETCH_ICACHE_REFILL_PREDECODE_EN
  assign pd_s = predecode(beat_data_r);
`else
  assign pd_s = 4'b0000;
`endif

  // Next-state, timeout detection and timeout counter update.
  always_comb begin
    state_nx  = state_r;
    timeout_s = 1'b0;
    timer_nx  = 32'd0;
    case (state_r)
      IDLE: begin
        if (miss_valid) begin
          state_nx = REQ;
        end else begin
          state_nx = IDLE;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_nx = FILL;
        end else if (TO_EN && (timer_r == TO_LAST)) begin
          timeout_s = 1'b1;
          state_nx  = IDLE;
        end else begin
          state_nx = REQ;
        end
      end
      FILL: begin
        // Leave only after the last beat's data write has been issued.
        if (beat_valid_r && (beat_idx_r == 4'd15)) begin
          state_nx = TAG;
        end else if (TO_EN && !beat_take_s && (timer_r == TO_LAST)) begin
          timeout_s = 1'b1;
          state_nx  = IDLE;
        end else begin
          state_nx = FILL;
        end
      end
      TAG: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (!TO_EN || ((state_nx != REQ) && (state_nx != FILL))) begin
      timer_nx = 32'd0;
    end else if ((state_nx != state_r) || beat_take_s) begin
      timer_nx = 32'd0;
    end else begin
      timer_nx = timer_r + 32'd1;
    end
  end

  // State, line context and beat pipeline registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= IDLE;
      line_r       <= 26'd0;
      poison_r     <= 1'b0;
      cnt_r        <= 5'd0;
      beat_valid_r <= 1'b0;
      beat_idx_r   <= 4'd0;
      beat_data_r  <= 32'd0;
      timer_r      <= 32'd0;
    end else begin
      state_r      <= state_nx;
      timer_r      <= timer_nx;
      beat_valid_r <= beat_take_s;
      if ((state_r == IDLE) && miss_valid) begin
        line_r   <= miss_addr[31:6];
        poison_r <= 1'b0;
        cnt_r    <= 5'd0;
      end else begin
        if (snoop_match_s) begin
          poison_r <= 1'b1;
        end
        if (beat_take_s) begin
          cnt_r <= cnt_r + 5'd1;
        end
      end
      if (beat_take_s) begin
        beat_idx_r  <= cnt_r[3:0];
        beat_data_r <= mem_resp_data;
      end
    end
  end

  assign miss_ready    = (state_r == IDLE);
  assign refill_busy   = (state_r != IDLE);
  assign mem_req_valid = (state_r == REQ);
  assign mem_req_addr  = mem_req_valid ? {line_r, 6'b000000} : 32'd0;

  assign update_data_wea  = beat_valid_r;
  assign update_data_addr = beat_valid_r ? {line_r, beat_idx_r, 2'b00} : 32'd0;
  assign update_data      = beat_valid_r ? {pd_s, beat_data_r} : 36'd0;

  // A snoop landing on the tag-write cycle itself must still keep the line invalid.
  assign update_tag_wea = (state_r == TAG);
  assign update_tag     = update_tag_wea ? {~(poison_r | snoop_match_s), line_r, 6'b000000} : 33'd0;
  assign refill_done    = update_tag_wea;
  assign refill_err     = timeout_s;

endmodule

// File: tb/tb_fetch_icache_refill.sv
// Directed self-checking bench for fetch_icache_refill: refills, snoop poisoning,
// request timeout, mid-refill reset and predecode bits.
module tb_fetch_icache_refill;

  logic        clk = 1'b0;
  logic        resetn;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        snoop_hit;
  logic [31:0] snoop_addr;
  logic        update_data_wea;
  logic [31:0] update_data_addr;
  logic [35:0] update_data;
  logic        update_tag_wea;
  logic [32:0] update_tag;
  logic        refill_busy;
  logic        refill_done;
  logic        refill_err;

`ifdef FETCH_ICACHE_REFILL_PREDECODE_EN
  localparam bit PD = 1'b1;
`else
  localparam bit PD = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_icache_refill #(.TIMEOUT_CYCLES(1024)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .miss_valid       (miss_valid),
    .miss_addr        (miss_addr),
    .miss_ready       (miss_ready),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_ready    (mem_req_ready),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_data    (mem_resp_data),
    .snoop_hit        (snoop_hit),
    .snoop_addr       (snoop_addr),
    .update_data_wea  (update_data_wea),
    .update_data_addr (update_data_addr),
    .update_data      (update_data),
    .update_tag_wea   (update_tag_wea),
    .update_tag       (update_tag),
    .refill_busy      (refill_busy),
    .refill_done      (refill_done),
    .refill_err       (refill_err)
  );

  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Write log, sampled mid-cycle.
  logic [31:0] dw_addr[256];
  logic [35:0] dw_data[256];
  int          dw_cyc[256];
  int          dw_n = 0;
  int          tw_n = 0;

  always @(negedge clk) begin
    if (update_data_wea === 1'b1) begin
      if (dw_n < 256) begin
        dw_addr[dw_n] = update_data_addr;
        dw_data[dw_n] = update_data;
        dw_cyc[dw_n]  = cyc;
      end
      dw_n++;
    end
    if (update_tag_wea === 1'b1) tw_n++;
  end

  logic [31:0] words[16];
  logic [3:0]  exp_pd[16];
  int          beat_cyc[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs_zero(input string nm);
    check({nm, "_req_addr"}, 64'(mem_req_addr), 64'd0);
    check({nm, "_dw_addr"}, 64'(update_data_addr), 64'd0);
    check({nm, "_dw_data"}, 64'(update_data), 64'd0);
    check({nm, "_tag"}, 64'(update_tag), 64'd0);
    check({nm, "_ctrl"},
          64'({miss_ready, mem_req_valid, update_data_wea, update_tag_wea,
               refill_busy, refill_done, refill_err}),
          64'(7'b1000000));
  endtask

  task automatic refill(input string nm, input logic [31:0] addr, input int sbeat,
                        input logic [31:0] saddr, input logic exp_valid);
    int base;
    int tbase;
    base  = dw_n;
    tbase = tw_n;
    miss_valid = 1'b1;
    miss_addr  = addr;
    check({nm, "_idle_ready"}, 64'(miss_ready), 64'd1);
    check({nm, "_req_pre"}, 64'(mem_req_valid), 64'd0);
    step();
    miss_valid = 1'b0;
    miss_addr  = 32'd0;
    check({nm, "_req_valid"}, 64'(mem_req_valid), 64'd1);
    check({nm, "_req_addr"}, 64'(mem_req_addr), 64'({addr[31:6], 6'b000000}));
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = words[i];
      snoop_hit      = (i == sbeat);
      snoop_addr     = (i == sbeat) ? saddr : 32'd0;
      beat_cyc[i]    = cyc;
      step();
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    snoop_hit      = 1'b0;
    snoop_addr     = 32'd0;
    check({nm, "_done_early"}, 64'(refill_done), 64'd0);
    step();
    check({nm, "_tag_cyc"}, 64'(cyc), 64'(beat_cyc[15] + 2));
    check({nm, "_tag_wea"}, 64'(update_tag_wea), 64'd1);
    check({nm, "_done"}, 64'(refill_done), 64'd1);
    check({nm, "_tag"}, 64'(update_tag), 64'({exp_valid, addr[31:6], 6'b000000}));
    check({nm, "_ready_tag"}, 64'(miss_ready), 64'd0);
    step();
    check({nm, "_ready_after"}, 64'(miss_ready), 64'd1);
    check({nm, "_busy_after"}, 64'(refill_busy), 64'd0);
    check({nm, "_n_dw"}, 64'(dw_n - base), 64'd16);
    check({nm, "_n_tw"}, 64'(tw_n - tbase), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check({nm, "_dw_addr"}, 64'(dw_addr[base + i]),
            64'({addr[31:6], 6'b000000}) + 64'(4 * i));
      check({nm, "_dw_data"}, 64'(dw_data[base + i]), 64'({exp_pd[i], words[i]}));
      check({nm, "_dw_cyc"}, 64'(dw_cyc[base + i]), 64'(beat_cyc[i] + 1));
    end
  endtask

  initial begin
    int k;
    int base;
    int tbase;
    resetn = 1'b0;
    miss_valid = 1'b0;
    miss_addr = 32'd0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = 32'd0;
    snoop_hit = 1'b0;
    snoop_addr = 32'd0;
    step();
    step();
    outs_zero("rst");
    resetn = 1'b1;
    step();

    // Sequential beat words; 0x1008 is JR and 0x1009 is JALR when decoded.
    for (int i = 0; i < 16; i++) begin
      words[i]  = 32'h0000_1000 + 32'(i);
      exp_pd[i] = 4'b0000;
    end
    exp_pd[8] = PD ? 4'b0001 : 4'b0000;
    exp_pd[9] = PD ? 4'b0011 : 4'b0000;

    refill("basic", 32'h0000_1A40, -1, 32'd0, 1'b1);
    refill("snoop_same", 32'h0000_1A40, 7, 32'h0000_1A44, 1'b0);
    refill("snoop_other", 32'h0000_1A40, 7, 32'h0000_2A40, 1'b1);

    // Request never accepted: abort on the 1024th REQ cycle.
    tbase = tw_n;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_3000;
    step();
    miss_valid = 1'b0;
    k = 1;
    while ((refill_err !== 1'b1) && (k < 1100)) begin
      step();
      k++;
    end
    check("to_cycle", 64'(k), 64'd1024);
    check("to_err", 64'(refill_err), 64'd1);
    check("to_tag_wea", 64'(update_tag_wea), 64'd0);
    step();
    check("to_ready", 64'(miss_ready), 64'd1);
    check("to_err_clr", 64'(refill_err), 64'd0);
    check("to_n_tw", 64'(tw_n - tbase), 64'd0);

    // Reset after beat 5, then stray beats must be dropped.
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_4A40;
    step();
    miss_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_5000 + 32'(i);
      step();
    end
    mem_resp_valid = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    outs_zero("mid_rst");
    base  = dw_n;
    tbase = tw_n;
    for (int i = 0; i < 10; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hDEAD_0000 + 32'(i);
      step();
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    step();
    step();
    check("stray_n_dw", 64'(dw_n - base), 64'd0);
    check("stray_n_tw", 64'(tw_n - tbase), 64'd0);
    outs_zero("stray");

    // JAL and JR words for the predecode bits.
    for (int i = 0; i < 16; i++) begin
      words[i]  = 32'd0;
      exp_pd[i] = 4'b0000;
    end
    words[0]  = 32'h0C00_0010;
    words[1]  = 32'h0000_0008;
    exp_pd[0] = PD ? 4'b0011 : 4'b0000;
    exp_pd[1] = PD ? 4'b0001 : 4'b0000;
    refill("pd", 32'h0000_6000, -1, 32'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
